// File: rtl/rob_nway_if.sv
// Signal bundle between the reorder buffer and its rename, execute and commit neighbours.
// The master side drives enqueue/completion; the slave side is the ROB itself.
interface rob_nway_if #(
  parameter int DEPTH = 64,
  parameter int CW    = 2,
  parameter int NCP   = 2,
  parameter int TW    = $clog2(DEPTH)
);
  logic              i_enq_valid;
  logic              o_enq_ready;
  logic [TW-1:0]     o_enq_tag;
  logic              i_enq_regwr;
  logic [4:0]        i_enq_areg;
  logic [5:0]        i_enq_preg;
  logic              i_enq_is_br;
  logic              i_enq_is_sys;
  logic [31:0]       i_enq_pc;

  logic [NCP-1:0]    i_cmp_valid;
  logic [NCP*TW-1:0] i_cmp_tag;
  logic [NCP-1:0]    i_cmp_mispred;
  logic [NCP*32-1:0] i_cmp_alt_pc;

  logic [CW-1:0]     o_cm_valid;
  logic [CW*5-1:0]   o_cm_areg;
  logic [CW*6-1:0]   o_cm_preg;
  logic [CW-1:0]     o_cm_regwr;

  logic              o_flush;
  logic              o_redirect_valid;
  logic [31:0]       o_redirect_pc;
  logic              o_sys;
  logic [TW-1:0]     o_head_tag;
  logic [TW:0]       o_count;

  modport master (
    output i_enq_valid, i_enq_regwr, i_enq_areg, i_enq_preg, i_enq_is_br,
           i_enq_is_sys, i_enq_pc, i_cmp_valid, i_cmp_tag, i_cmp_mispred,
           i_cmp_alt_pc,
    input  o_enq_ready, o_enq_tag, o_cm_valid, o_cm_areg, o_cm_preg,
           o_cm_regwr, o_flush, o_redirect_valid, o_redirect_pc, o_sys,
           o_head_tag, o_count
  );

  modport slave (
    input  i_enq_valid, i_enq_regwr, i_enq_areg, i_enq_preg, i_enq_is_br,
           i_enq_is_sys, i_enq_pc, i_cmp_valid, i_cmp_tag, i_cmp_mispred,
           i_cmp_alt_pc,
    output o_enq_ready, o_enq_tag, o_cm_valid, o_cm_areg, o_cm_preg,
           o_cm_regwr, o_flush, o_redirect_valid, o_redirect_pc, o_sys,
           o_head_tag, o_count
  );
endinterface

// File: rtl/rob_nway.sv
// N-wide in-order-commit reorder buffer with multi-port completion.
// A mispredicted branch or syscall ends its commit group and flushes the whole buffer.
module rob_nway #(
  parameter int DEPTH = 64,
  parameter int CW    = 2,
  parameter int NCP   = 2,
  parameter int TW    = $clog2(DEPTH)
) (
  input  logic     CLK,
  input  logic     RESET,
  rob_nway_if.slave bus
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_done;
  logic [DEPTH-1:0] r_regwr;
  logic [DEPTH-1:0] r_isBr;
  logic [DEPTH-1:0] r_isSys;
  logic [DEPTH-1:0] r_mispred;
  logic [4:0]       r_areg  [DEPTH];
  logic [5:0]       r_preg  [DEPTH];
  logic [31:0]      r_pc    [DEPTH];
  logic [31:0]      r_altPc [DEPTH];

  logic [TW-1:0]    r_head;
  logic [TW-1:0]    r_tail;
  logic [TW:0]      r_count;

  logic [CW-1:0]    r_cmValid;
  logic [CW*5-1:0]  r_cmAreg;
  logic [CW*6-1:0]  r_cmPreg;
  logic [CW-1:0]    r_cmRegwr;
  logic             r_flush;
  logic             r_redirValid;
  logic [31:0]      r_redirPc;
  logic             r_sys;

  logic             w_enqReady;
  logic             w_enqFire;
  logic [TW-1:0]    w_slotIdx [CW];
  logic [CW-1:0]    w_cmSlot;
  logic [TW:0]      w_cmNum;
  logic             w_term;
  logic             w_stop;
  logic [TW-1:0]    w_termIdx;
  logic [31:0]      w_termPc;

  // Using the registered count keeps enqueue blocked at full even if a commit frees a slot this cycle.
  assign w_enqReady = (r_count < (TW+1)'(DEPTH)) && !r_flush;
  assign w_enqFire  = bus.i_enq_valid && w_enqReady;

  always_comb begin
    for (int i = 0; i < CW; i++) begin
      w_slotIdx[i] = r_head + TW'(i);
    end
  end

  // Commit scan: a flush cycle commits nothing; a terminating entry is the last slot of its group.
  always_comb begin
    w_cmSlot  = '0;
    w_cmNum   = '0;
    w_term    = 1'b0;
    w_termIdx = '0;
    w_stop    = r_flush;
    for (int i = 0; i < CW; i++) begin
      if (!w_stop) begin
        if (r_valid[w_slotIdx[i]] && r_done[w_slotIdx[i]]) begin
          w_cmSlot[i] = 1'b1;
          w_cmNum     = w_cmNum + (TW+1)'(1);
          if ((r_isBr[w_slotIdx[i]] && r_mispred[w_slotIdx[i]]) || r_isSys[w_slotIdx[i]]) begin
            w_term    = 1'b1;
            w_termIdx = w_slotIdx[i];
            w_stop    = 1'b1;
          end
        end else begin
          w_stop = 1'b1;
        end
      end
    end
  end

  assign w_termPc = (r_isBr[w_termIdx] && r_mispred[w_termIdx]) ? r_altPc[w_termIdx]
                                                               : r_pc[w_termIdx] + 32'd4;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid   <= '0;
      r_done    <= '0;
      r_regwr   <= '0;
      r_isBr    <= '0;
      r_isSys   <= '0;
      r_mispred <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        r_areg[e]  <= '0;
        r_preg[e]  <= '0;
        r_pc[e]    <= '0;
        r_altPc[e] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_term) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enqFire) begin
        r_valid[r_tail]   <= 1'b1;
        r_done[r_tail]    <= 1'b0;
        r_regwr[r_tail]   <= bus.i_enq_regwr;
        r_isBr[r_tail]    <= bus.i_enq_is_br;
        r_isSys[r_tail]   <= bus.i_enq_is_sys;
        r_mispred[r_tail] <= 1'b0;
        r_areg[r_tail]    <= bus.i_enq_areg;
        r_preg[r_tail]    <= bus.i_enq_preg;
        r_pc[r_tail]      <= bus.i_enq_pc;
        r_altPc[r_tail]   <= '0;
        r_tail            <= r_tail + TW'(1);
      end
      // Walking ports high-to-low lets the lowest-numbered port's update land last and win.
      if (!r_flush) begin
        for (int p = NCP - 1; p >= 0; p--) begin
          if (bus.i_cmp_valid[p] && r_valid[bus.i_cmp_tag[p*TW +: TW]]) begin
            r_done[bus.i_cmp_tag[p*TW +: TW]] <= 1'b1;
            if (r_isBr[bus.i_cmp_tag[p*TW +: TW]]) begin
              r_mispred[bus.i_cmp_tag[p*TW +: TW]] <= bus.i_cmp_mispred[p];
              r_altPc[bus.i_cmp_tag[p*TW +: TW]]   <= bus.i_cmp_alt_pc[p*32 +: 32];
            end
          end
        end
      end
      for (int i = 0; i < CW; i++) begin
        if (w_cmSlot[i]) begin
          r_valid[w_slotIdx[i]] <= 1'b0;
          r_done[w_slotIdx[i]]  <= 1'b0;
        end
      end
      r_head  <= r_head + w_cmNum[TW-1:0];
      r_count <= r_count + (TW+1)'(w_enqFire) - w_cmNum;
    end
  end

  // Commit and redirect outputs are registered; idle slots are driven to zero.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cmValid    <= '0;
      r_cmAreg     <= '0;
      r_cmPreg     <= '0;
      r_cmRegwr    <= '0;
      r_flush      <= 1'b0;
      r_redirValid <= 1'b0;
      r_redirPc    <= '0;
      r_sys        <= 1'b0;
    end else begin
      for (int i = 0; i < CW; i++) begin
        r_cmValid[i]       <= w_cmSlot[i];
        r_cmAreg[i*5 +: 5] <= w_cmSlot[i] ? r_areg[w_slotIdx[i]] : 5'd0;
        r_cmPreg[i*6 +: 6] <= w_cmSlot[i] ? r_preg[w_slotIdx[i]] : 6'd0;
        r_cmRegwr[i]       <= w_cmSlot[i] && r_regwr[w_slotIdx[i]];
      end
      r_flush      <= w_term;
      r_redirValid <= w_term;
      r_redirPc    <= w_term ? w_termPc : 32'd0;
      r_sys        <= w_term && r_isSys[w_termIdx];
    end
  end

  assign bus.o_enq_ready      = w_enqReady;
  assign bus.o_enq_tag        = r_tail;
  assign bus.o_head_tag       = r_head;
  assign bus.o_count          = r_count;
  assign bus.o_cm_valid       = r_cmValid;
  assign bus.o_cm_areg        = r_cmAreg;
  assign bus.o_cm_preg        = r_cmPreg;
  assign bus.o_cm_regwr       = r_cmRegwr;
  assign bus.o_flush          = r_flush;
  assign bus.o_redirect_valid = r_redirValid;
  assign bus.o_redirect_pc    = r_redirPc;
  assign bus.o_sys            = r_sys;

endmodule
